// File: rtl/save_ram_arbiter_if.sv
// Bus bundle between the save RAM arbiter, the GBA cart interface, the host port and the RAM.
// slave is the arbiter's view; master is the view of everything around it.
interface save_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] gba_addr;
  logic [7:0]        gba_wdata;
  logic              gba_write;
  logic              gba_read;
  logic [7:0]        gba_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;

  logic              dirty;
  logic              dirty_clr;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport slave (
    input  gba_addr, gba_wdata, gba_write, gba_read,
    input  host_req, host_we, host_addr, host_wdata,
    input  dirty_clr, mem_rdata,
    output gba_rdata, host_ack, host_rdata, dirty,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output gba_addr, gba_wdata, gba_write, gba_read,
    output host_req, host_we, host_addr, host_wdata,
    output dirty_clr, mem_rdata,
    input  gba_rdata, host_ack, host_rdata, dirty,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/save_ram_arbiter.sv
// Save RAM arbiter: one slot per cycle between GBA writes, GBA reads and a host port.
// Slot chosen in cycle N drives the RAM in N+1; its read data is captured at the end of N+1.
module save_ram_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  save_ram_arbiter_if.slave bus
);
  localparam int unsigned      WaitW   = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(HOST_MAX_WAIT);

  typedef enum logic [2:0] {
    SlotIdle,
    SlotGbaWr,
    SlotGbaRd,
    SlotHostRd,
    SlotHostWr
  } slot_e;

  slot_e             slot_d, slot_q;
  logic              gba_write_prev_q;
  logic              wr_pend_d, wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [7:0]        wr_data_d, wr_data_q;
  logic              host_busy_d, host_busy_q;
  logic [WaitW-1:0]  wait_cnt_d, wait_cnt_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [7:0]        mem_wdata_d, mem_wdata_q;
  logic              mem_we_d, mem_we_q;
  logic [7:0]        gba_rdata_d, gba_rdata_q;
  logic              host_ack_d, host_ack_q;
  logic [7:0]        host_rdata_d, host_rdata_q;
  logic              dirty_d, dirty_q;
  logic              host_elig, host_force, host_grant;

  // The ack cycle also blocks the host so a request held through it restarts one cycle later.
  assign host_elig  = bus.host_req && !host_busy_q && !host_ack_q;
  assign host_force = host_elig && (wait_cnt_q >= WaitMax);
  assign host_grant = (slot_d == SlotHostRd) || (slot_d == SlotHostWr);

  always_comb begin
    slot_d = SlotIdle;
    if (wr_pend_q)        slot_d = SlotGbaWr;
    else if (host_force)  slot_d = bus.host_we ? SlotHostWr : SlotHostRd;
    else if (bus.gba_read) slot_d = SlotGbaRd;
    else if (host_elig)   slot_d = bus.host_we ? SlotHostWr : SlotHostRd;
  end

  always_comb begin
    wr_pend_d    = wr_pend_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    host_busy_d  = host_busy_q;
    wait_cnt_d   = wait_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    gba_rdata_d  = gba_rdata_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;

    if (bus.gba_write) begin
      wr_addr_d = bus.gba_addr;
      wr_data_d = bus.gba_wdata;
    end

    case (slot_d)
      SlotGbaWr: begin
        mem_addr_d  = wr_addr_q;
        mem_wdata_d = wr_data_q;
        mem_we_d    = 1'b1;
        wr_pend_d   = 1'b0;
      end
      SlotGbaRd: mem_addr_d = bus.gba_addr;
      SlotHostRd: begin
        mem_addr_d  = bus.host_addr;
        host_busy_d = 1'b1;
      end
      SlotHostWr: begin
        mem_addr_d  = bus.host_addr;
        mem_wdata_d = bus.host_wdata;
        mem_we_d    = 1'b1;
        host_busy_d = 1'b1;
      end
      default: ;
    endcase

    if (gba_write_prev_q && !bus.gba_write) wr_pend_d = 1'b1;

    // Completion of the slot issued last cycle; the RAM answers its registered address now.
    case (slot_q)
      SlotGbaRd: gba_rdata_d = bus.mem_rdata;
      SlotHostRd: begin
        host_rdata_d = bus.mem_rdata;
        host_ack_d   = 1'b1;
        host_busy_d  = 1'b0;
      end
      SlotHostWr: begin
        host_ack_d  = 1'b1;
        host_busy_d = 1'b0;
      end
      default: ;
    endcase

    if (!bus.host_req || host_grant)              wait_cnt_d = '0;
    else if (host_elig && (wait_cnt_q < WaitMax)) wait_cnt_d = wait_cnt_q + 1'b1;

    // Set covers both the grant and the mem_we cycle so a clear in either loses.
    dirty_d = (dirty_q && !bus.dirty_clr) || (slot_d == SlotGbaWr) || (slot_q == SlotGbaWr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q           <= SlotIdle;
      gba_write_prev_q <= 1'b0;
      wr_pend_q        <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      host_busy_q      <= 1'b0;
      wait_cnt_q       <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_we_q         <= 1'b0;
      gba_rdata_q      <= '0;
      host_ack_q       <= 1'b0;
      host_rdata_q     <= '0;
      dirty_q          <= 1'b0;
    end else begin
      slot_q           <= slot_d;
      gba_write_prev_q <= bus.gba_write;
      wr_pend_q        <= wr_pend_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      host_busy_q      <= host_busy_d;
      wait_cnt_q       <= wait_cnt_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_we_q         <= mem_we_d;
      gba_rdata_q      <= gba_rdata_d;
      host_ack_q       <= host_ack_d;
      host_rdata_q     <= host_rdata_d;
      dirty_q          <= dirty_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.gba_rdata  = gba_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.dirty      = dirty_q;
endmodule

// File: tb/tb_save_ram_arbiter.sv
// Bench for save_ram_arbiter: directed scenarios, then random GBA/host traffic against a
// shadow memory model with bounded host latency.
module tb_save_ram_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned MAXW = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   we_cnt = 0;
  int   we_base, age, wr_left, gba_wr_n, host_wr_n;
  logic [7:0]  ram [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  exp_rd;
  logic [7:0]  model_g [0:255];
  logic [7:0]  model_h [0:255];
  bit          valid_g [0:255];
  bit          valid_h [0:255];
  logic [7:0]  g_idx, h_idx;
  bit          h_we, just_acked;

  save_ram_arbiter_if #(.ADDR_W(AW)) bus ();

  save_ram_arbiter #(.ADDR_W(AW), .HOST_MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM: asynchronous read of the registered address, write on the clock.
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic host_observe();
    just_acked = 1'b0;
    if (bus.host_req) begin
      age++;
      if (bus.host_ack) begin
        check("rnd_host_latency", 32'(age <= int'(MAXW) + 3), 1);
        if (h_we) begin
          model_h[h_idx] = bus.host_wdata; valid_h[h_idx] = 1'b1; host_wr_n++;
        end else check("rnd_host_rd", bus.host_rdata, model_h[h_idx]);
        bus.host_req = 1'b0; just_acked = 1'b1;
      end else if (age > int'(MAXW) + 3) begin
        check("rnd_host_timeout", 0, 1);
        bus.host_req = 1'b0; just_acked = 1'b1;
      end
    end
  endtask

  task automatic gba_commit();
    bus.gba_write = 1'b0;
    model_g[g_idx] = bus.gba_wdata; valid_g[g_idx] = 1'b1; gba_wr_n++;
  endtask

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.gba_addr = '0; bus.gba_wdata = '0; bus.gba_write = 1'b0; bus.gba_read = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.dirty_clr = 1'b0;
    preload(16'h0040, 8'h77);
    preload(16'h0041, 8'h88);
    preload(16'h0200, 8'hC3);
    preload(16'h0400, 8'h5E);
    for (int i = 0; i < 40; i++) preload(16'h0300 + 16'(i), 8'h10 + 8'(i));

    // Reset with a live host request and a toggling write strobe.
    bus.host_req = 1'b1; bus.gba_addr = 16'h0055; bus.gba_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      bus.gba_write = (i % 2 == 0);
      tick();
      check("rst_outs", {bus.mem_we, bus.host_ack, bus.dirty, bus.gba_rdata, bus.host_rdata}, 0);
      check("rst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
    end
    we_base = we_cnt;
    rst = 1'b0; bus.host_req = 1'b0; bus.gba_write = 1'b0;
    repeat (3) tick();
    check("post_rst_quiet", {bus.host_ack, bus.dirty}, 0);
    check("post_rst_no_we", we_cnt - we_base, 0);

    // GBA write: high three cycles, then the fall; one mem_we two cycles later.
    we_base = we_cnt;
    bus.gba_addr = 16'h0123; bus.gba_wdata = 8'h5A; bus.gba_write = 1'b1;
    repeat (3) tick();
    bus.gba_write = 1'b0;
    tick();
    check("wr_fall+1_we", bus.mem_we, 0);
    tick();
    check("wr_fall+2_we", bus.mem_we, 1);
    check("wr_addr", bus.mem_addr, 16'h0123);
    check("wr_data", bus.mem_wdata, 8'h5A);
    check("wr_dirty", bus.dirty, 1);
    tick();
    check("wr_single", we_cnt - we_base, 1);
    check("wr_ram", ram[16'h0123], 8'h5A);

    // GBA read: data two cycles after the read starts, then follows the address.
    bus.gba_addr = 16'h0040; bus.gba_read = 1'b1;
    tick(); tick();
    check("rd_0040", bus.gba_rdata, 8'h77);
    bus.gba_addr = 16'h0041;
    tick();
    check("rd_hold", bus.gba_rdata, 8'h77);
    tick();
    check("rd_0041", bus.gba_rdata, 8'h88);
    bus.gba_read = 1'b0;
    tick();

    // Host read then host write on an idle bus.
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0200;
    tick();
    check("hrd_ack_early", bus.host_ack, 0);
    check("hrd_mem_addr", bus.mem_addr, 16'h0200);
    tick();
    check("hrd_ack", bus.host_ack, 1);
    check("hrd_data", bus.host_rdata, 8'hC3);
    bus.host_req = 1'b0;
    tick();
    check("hrd_ack_pulse", bus.host_ack, 0);
    we_base = we_cnt;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h0201; bus.host_wdata = 8'h99;
    tick();
    check("hwr_we", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 16'h0201, 8'h99});
    tick();
    check("hwr_ack", bus.host_ack, 1);
    check("hwr_rdata_kept", bus.host_rdata, 8'hC3);
    bus.host_req = 1'b0;
    tick();
    check("hwr_single", we_cnt - we_base, 1);
    check("hwr_ram", ram[16'h0201], 8'h99);

    // Continuous reads starve the host until its wait reaches the limit.
    bus.host_we = 1'b0; bus.host_addr = 16'h0400;
    for (int k = 0; k < 40; k++) begin
      bus.gba_addr = 16'h0300 + 16'(k); bus.gba_read = 1'b1;
      if (k == 5) bus.host_req = 1'b1;
      if (k == 15) bus.host_req = 1'b0;
      tick();
      if (k + 1 >= 2) begin
        if (k - 1 != 13) exp_rd = 8'h10 + 8'(k - 1);
        check("starve_gba_rdata", bus.gba_rdata, exp_rd);
      end
      if (k + 1 >= 6 && k + 1 <= 14) check("starve_no_ack", bus.host_ack, 0);
      if (k + 1 == 14) check("starve_grant13", bus.mem_addr, 16'h0400);
      if (k + 1 == 15) check("starve_ack15", {bus.host_ack, bus.host_rdata}, {1'b1, 8'h5E});
    end
    bus.gba_read = 1'b0;
    tick();

    // Write becomes pending as a host read arrives; dirty_clr collides with the commit.
    bus.dirty_clr = 1'b1;
    tick();
    bus.dirty_clr = 1'b0;
    check("dirty_cleared", bus.dirty, 0);
    bus.gba_addr = 16'h0500; bus.gba_wdata = 8'hA5; bus.gba_write = 1'b1;
    tick();
    bus.gba_write = 1'b0;
    tick();
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0500;
    tick();
    check("col_wr_first", {bus.mem_we, bus.mem_addr}, {1'b1, 16'h0500});
    bus.dirty_clr = 1'b1;
    tick();
    bus.dirty_clr = 1'b0;
    check("col_dirty_set_wins", bus.dirty, 1);
    check("col_no_ack_yet", bus.host_ack, 0);
    tick();
    check("col_host_next", {bus.host_ack, bus.host_rdata}, {1'b1, 8'hA5});
    bus.host_req = 1'b0;
    tick();
    bus.dirty_clr = 1'b1;
    tick();
    bus.dirty_clr = 1'b0;
    check("col_dirty_clr_later", bus.dirty, 0);

    // Random traffic: GBA writes in 0x10xx, host in 0x20xx, reads anywhere.
    for (int i = 0; i < 256; i++) begin valid_g[i] = 1'b0; valid_h[i] = 1'b0; end
    gba_wr_n = 0; host_wr_n = 0; wr_left = 0; age = 0; g_idx = '0; h_idx = '0; h_we = 1'b0;
    we_base = we_cnt;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      host_observe();
      if (bus.gba_write) begin
        if (wr_left == 0) gba_commit();
        else wr_left--;
      end else if ($urandom_range(3) == 0) begin
        g_idx = 8'($urandom_range(255));
        bus.gba_addr = 16'h1000 | {8'h00, g_idx}; bus.gba_wdata = 8'($urandom);
        bus.gba_write = 1'b1; wr_left = $urandom_range(2);
      end else bus.gba_addr = 16'($urandom);
      bus.gba_read = ($urandom_range(1) == 1);
      if (!bus.host_req && !just_acked && $urandom_range(2) == 0) begin
        h_idx = 8'($urandom_range(255));
        h_we = !valid_h[h_idx] || ($urandom_range(1) == 1);
        bus.host_we = h_we; bus.host_addr = 16'h2000 | {8'h00, h_idx};
        bus.host_wdata = 8'($urandom); bus.host_req = 1'b1; age = 0;
      end
      tick();
    end
    if (bus.gba_write) gba_commit();
    bus.gba_read = 1'b0;
    for (int i = 0; i < 12 && bus.host_req; i++) begin
      host_observe();
      if (bus.host_req) tick();
    end
    check("drain_host_idle", bus.host_req, 0);
    repeat (4) tick();
    check("rnd_we_count", we_cnt - we_base, gba_wr_n + host_wr_n);
    for (int i = 0; i < 256; i++) begin
      if (valid_g[i]) check("rnd_gba_ram", ram[16'h1000 + 16'(i)], model_g[i]);
      if (valid_h[i]) check("rnd_host_ram", ram[16'h2000 + 16'(i)], model_h[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/save_ram_arbiter.md
Name: save_ram_arbiter

Overview:
Shares the single-port 8-bit cartridge save RAM between the GBA cartridge bus (CS2 region, via the cart interface's addr/mosi/write path) and a host-side requester (debug/dump port). Turns the GBA interface's level write strobe into exactly one memory write per access. Serves GBA reads every free cycle. Gives the host bounded-latency access and tracks a save-dirty flag for the host.

Parameters:
ADDR_W, 16, save RAM address width
HOST_MAX_WAIT, 8, max cycles a pending host request may be starved before a forced host slot (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
gba_addr  in  ADDR_W  address from cart interface
gba_wdata  in  8  write data from cart interface
gba_write  in  1  level write strobe (synchronized nWR & nCS2)
gba_read  in  1  level read strobe (synchronized nRD & nCS2)
gba_rdata  out  8  read data to cart interface
host_req  in  1  host request, held until host_ack
host_we  in  1  1=write, 0=read; stable while host_req
host_addr  in  ADDR_W  host address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  8  host read data, valid with host_ack, held after
dirty  out  1  set by any committed GBA write
dirty_clr  in  1  host clears dirty
mem_addr  out  ADDR_W  RAM address (registered)
mem_wdata  out  8  RAM write data (registered)
mem_we  out  1  RAM write enable (registered, one-cycle pulses)
mem_rdata  in  8  RAM read data, one cycle after mem_addr

Behaviour:
- Reset: every output 0. Pending write, host in-flight flag, wait counter and pipeline cleared. A host transaction in progress at reset is dropped: no ack, no mem_we.
- GBA write capture: every cycle gba_write=1, latch gba_addr and gba_wdata into wr_addr and wr_data. On the falling edge of gba_write (registered previous=1, current=0), set wr_pend.
- Slot arbitration each cycle N, strict priority:
  1. wr_pend (GBA write).
  2. Host forced: host_req, not in flight, wait_cnt>=HOST_MAX_WAIT.
  3. GBA read: gba_read=1.
  4. Host normal: host_req, not in flight.
  5. Otherwise idle.
- Pipeline: the slot chosen in cycle N drives mem_addr, mem_wdata and mem_we in N+1. mem_rdata is sampled at N+2.
  - GBA write slot: mem_we=1 at N+1 with wr_addr/wr_data. wr_pend clears at N. dirty set at N+1.
  - GBA read slot: mem_addr=gba_addr sampled at N. gba_rdata updated at N+2. gba_rdata holds on all other cycles.
  - Host slot: in-flight flag set at N. host_ack=1 at N+2, with host_rdata=mem_rdata for reads. host_rdata is unchanged for writes. In-flight clears at N+2.
  - Idle slot: mem_we=0. mem_addr holds its last value.
- Host protocol: one outstanding transaction. The requester may drop or change host_req only after host_ack. A request still high in the ack cycle counts as a new request from N+3.
- wait_cnt: increments each cycle host_req=1, not in flight, and not granted. Resets to 0 on grant or when host_req=0. Saturates at HOST_MAX_WAIT.
- Forced host slot: that cycle's GBA read refresh is skipped, so gba_rdata lags one extra slot.
- A write falling edge in the same cycle as an active gba_read sets wr_pend. The write then wins the next cycle.
- Consecutive GBA writes are at least 2 cycles apart (high then low), so wr_pend never overflows.
- dirty: set on a committed write, cleared by dirty_clr. If both happen in the same cycle, set wins.
- Address width: ADDR_W bits used as-is, no wrap logic.

Test Plan:
- Reset held 3 cycles with host_req=1 and gba_write toggling -> all outputs 0; no mem_we; no host_ack.
- gba_addr=0x0123, gba_wdata=0x5A, gba_write high 3 cycles then low -> exactly one mem_we pulse, 2 cycles after the fall, with mem_addr=0x0123 and mem_wdata=0x5A; dirty=1 from that cycle.
- RAM[0x0040]=0x77, gba_addr=0x0040, gba_read rises at cycle T -> gba_rdata=0x77 at T+2; address changed to 0x0041 (RAM=0x88) -> gba_rdata=0x88 two cycles later.
- Host read of 0x0200 (RAM=0xC3), bus idle -> granted the request cycle; host_ack one cycle at +2 with host_rdata=0xC3; host write of 0x99 to 0x0201 -> single mem_we, ack at +2, host_rdata unchanged.
- gba_read held 40 cycles, host_req raised at cycle 5, HOST_MAX_WAIT=8 -> host granted at cycle 13; host_ack at 15; gba_rdata skips exactly one refresh.
- GBA write falling edge in the same cycle a host request arrives, plus dirty_clr pulsed in the write-commit cycle -> GBA write first, host granted next cycle; dirty remains 1.
